// File: rtl/mem_access_stage_pkg.sv
// Shared constants for the memory-access stage: funct3 width codes, FSM states,
// byte-strobe patterns and the alignment/legality helpers used at latch time.
package mem_access_stage_pkg;

   localparam logic [2:0] LSU_B  = 3'b000;
   localparam logic [2:0] LSU_H  = 3'b001;
   localparam logic [2:0] LSU_W  = 3'b010;
   localparam logic [2:0] LSU_BU = 3'b100;
   localparam logic [2:0] LSU_HU = 3'b101;

   localparam logic [3:0] STRB_B    = 4'b0001;
   localparam logic [3:0] STRB_H_LO = 4'b0011;
   localparam logic [3:0] STRB_H_HI = 4'b1100;
   localparam logic [3:0] STRB_W    = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   function automatic logic funct3_ok(input logic [2:0] f3);
      return (f3 == LSU_B) || (f3 == LSU_H) || (f3 == LSU_W) ||
             (f3 == LSU_BU) || (f3 == LSU_HU);
   endfunction

   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
      logic bad;
      bad = 1'b0;
      case (f3)
         LSU_H, LSU_HU: bad = a[0];
         LSU_W:         bad = (a != 2'b00);
         default:       bad = 1'b0;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/halfword out of a load word and sign- or zero-extends
// it to 32 bits according to funct3.
module load_align
   import mem_access_stage_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr,
   input  logic [2:0]  funct3,
   output logic [31:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata[7:0];
      case (addr)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

      data = rdata;
      case (funct3)
         LSU_B:   data = {{24{byte_sel[7]}}, byte_sel};
         LSU_BU:  data = {24'h0, byte_sel};
         LSU_H:   data = {{16{half_sel[15]}}, half_sel};
         LSU_HU:  data = {16'h0, half_sel};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: one req/ack bus transaction per load/store, load alignment,
// write-back hand-off. Non-memory and illegal instructions go straight to RESP.
module mem_access_stage
   import mem_access_stage_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        rd_mem,
   input  logic        wr_mem,
   input  logic [31:0] rd_mem_addr,
   input  logic [31:0] wr_mem_addr,
   input  logic [31:0] wr_mem_data,
   input  logic [2:0]  funct3,
   input  logic [31:0] result,
   input  logic        wr_regfile,
   output logic        ready,
   output logic        done,
   output logic [31:0] wb_data,
   output logic        wb_en,
   output logic        err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output state_t      dbg_state
);

   // Handshake: upstream holds req until it sees ready=1 at a rising edge; that edge
   // accepts. mem_req stays high until the cycle mem_ack=1 (or timeout), then drops.

   localparam logic [7:0] TMO = TIMEOUT[7:0];

   state_t      state, state_nxt;
   logic [31:0] addr_q, wdata_q, wb_data_q;
   logic [3:0]  wstrb_q;
   logic [2:0]  funct3_q;
   logic [1:0]  lane_q;
   logic        we_q, wb_en_q, err_q;
   logic [7:0]  tmo_cnt;

   logic        accept, is_mem, bad, timeout_hit;
   logic [31:0] sel_addr, st_wdata, ld_data;
   logic [3:0]  st_wstrb;

   assign accept      = req && (state == ST_IDLE);
   assign is_mem      = rd_mem || wr_mem;
   assign sel_addr    = rd_mem ? rd_mem_addr : wr_mem_addr;
   assign bad         = is_mem && ((rd_mem && wr_mem) || !funct3_ok(funct3) ||
                                   misaligned(funct3, sel_addr[1:0]));
   assign timeout_hit = (TMO != 8'd0) && ((tmo_cnt + 8'd1) == TMO);

   always_comb begin
      st_wdata = wr_mem_data;
      st_wstrb = STRB_W;
      case (funct3[1:0])
         2'b00: begin
            st_wdata = {4{wr_mem_data[7:0]}};
            st_wstrb = STRB_B << sel_addr[1:0];
         end
         2'b01: begin
            st_wdata = {2{wr_mem_data[15:0]}};
            st_wstrb = sel_addr[1] ? STRB_H_HI : STRB_H_LO;
         end
         default: begin
            st_wdata = wr_mem_data;
            st_wstrb = STRB_W;
         end
      endcase
   end

   load_align u_load_align (
      .rdata  (mem_rdata),
      .addr   (lane_q),
      .funct3 (funct3_q),
      .data   (ld_data)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (accept) state_nxt = (is_mem && !bad) ? ST_ACCESS : ST_RESP;
         ST_ACCESS: if (mem_ack || timeout_hit) state_nxt = ST_RESP;
         ST_RESP:   state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         funct3_q  <= '0;
         lane_q    <= '0;
         we_q      <= 1'b0;
         wb_data_q <= '0;
         wb_en_q   <= 1'b0;
         err_q     <= 1'b0;
         tmo_cnt   <= '0;
      end else if (accept) begin
         addr_q    <= {sel_addr[31:2], 2'b00};
         wdata_q   <= st_wdata;
         wstrb_q   <= wr_mem ? st_wstrb : 4'b0000;
         funct3_q  <= funct3;
         lane_q    <= sel_addr[1:0];
         we_q      <= wr_mem;
         wb_data_q <= result;
         wb_en_q   <= wr_regfile && !wr_mem && !bad;
         err_q     <= bad;
         tmo_cnt   <= '0;
      end else if (state == ST_ACCESS) begin
         if (mem_ack) begin
            if (!we_q) wb_data_q <= ld_data;
         end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
            if (timeout_hit) begin
               err_q   <= 1'b1;
               wb_en_q <= 1'b0;
            end
         end
      end
   end

   // Bus outputs are gated by state so an async reset clears them immediately.
   assign ready     = (state == ST_IDLE);
   assign done      = (state == ST_RESP);
   assign wb_data   = wb_data_q;
   assign wb_en     = done && wb_en_q;
   assign err       = done && err_q;
   assign mem_req   = (state == ST_ACCESS);
   assign mem_we    = mem_req && we_q;
   assign mem_addr  = mem_req ? addr_q  : 32'h0;
   assign mem_wdata = mem_req ? wdata_q : 32'h0;
   assign mem_wstrb = mem_req ? wstrb_q : 4'h0;
   assign dbg_state = state;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: pass-through, stores, loads with wait states,
// error/timeout paths, back-to-back acceptance and reset during a bus access.
module tb_mem_access_stage;
   import mem_access_stage_pkg::*;

   localparam int unsigned TB_TIMEOUT = 8;

   logic        clk, reset, req, rd_mem, wr_mem, wr_regfile, mem_ack;
   logic [31:0] rd_mem_addr, wr_mem_addr, wr_mem_data, result, mem_rdata;
   logic [2:0]  funct3;
   logic        ready, done, wb_en, err, mem_req, mem_we;
   logic [31:0] wb_data, mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   state_t      dbg_state;

   int errors = 0;
   int checks = 0;

   mem_access_stage #(.TIMEOUT(TB_TIMEOUT)) dut (
      .clk(clk), .reset(reset), .req(req), .rd_mem(rd_mem), .wr_mem(wr_mem),
      .rd_mem_addr(rd_mem_addr), .wr_mem_addr(wr_mem_addr), .wr_mem_data(wr_mem_data),
      .funct3(funct3), .result(result), .wr_regfile(wr_regfile), .ready(ready),
      .done(done), .wb_data(wb_data), .wb_en(wb_en), .err(err), .mem_req(mem_req),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents one instruction for one accepting edge; returns at cycle T+1.
   task automatic issue(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [2:0] f3,
                        input logic [31:0] res, input logic wrf);
      rd_mem = rd; wr_mem = wr; rd_mem_addr = addr; wr_mem_addr = addr;
      wr_mem_data = data; funct3 = f3; result = res; wr_regfile = wrf;
      req = 1'b1;
      step();
      req = 1'b0;
   endtask

   // Acks in the held-th ACCESS cycle; reports how many cycles mem_req was seen high.
   task automatic drive_ack(input int held, input logic [31:0] rdata, output int seen);
      seen = 0;
      for (int i = 0; i < held - 1; i++) begin
         if (mem_req === 1'b1) seen++;
         step();
      end
      if (mem_req === 1'b1) seen++;
      mem_ack = 1'b1; mem_rdata = rdata;
      step();
      mem_ack = 1'b0; mem_rdata = 32'h0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", ready); end
      checks++; if (done !== 1'b0 || wb_en !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_flags: done=%b wb_en=%b err=%b exp 0", done, wb_en, err); end
      checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_wstrb !== 4'h0) begin errors++; $display("FAIL reset_bus: req=%b we=%b strb=%h exp 0", mem_req, mem_we, mem_wstrb); end
      checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d exp %0d", dbg_state, ST_IDLE); end
      reset = 1'b0;
      step();
   endtask

   task automatic test_nonmem();
      issue(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 32'h0000_1234, 1'b1);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL nonmem_done: got %b exp 1", done); end
      checks++; if (wb_data !== 32'h0000_1234) begin errors++; $display("FAIL nonmem_wb_data: got %h exp 00001234", wb_data); end
      checks++; if (wb_en !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL nonmem_wb_en: wb_en=%b err=%b exp 1/0", wb_en, err); end
      checks++; if (mem_req !== 1'b0 || ready !== 1'b0) begin errors++; $display("FAIL nonmem_bus: mem_req=%b ready=%b exp 0/0", mem_req, ready); end
      step();
      checks++; if (done !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL nonmem_return: done=%b ready=%b exp 0/1", done, ready); end
   endtask

   task automatic test_store();
      int seen;
      issue(1'b0, 1'b1, 32'h0000_0103, 32'h0000_00AB, LSU_B, 32'h0, 1'b1);
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("FAIL sb_req: req=%b we=%b exp 1/1", mem_req, mem_we); end
      checks++; if (mem_addr !== 32'h0000_0100) begin errors++; $display("FAIL sb_addr: got %h exp 00000100", mem_addr); end
      checks++; if (mem_wstrb !== 4'b1000) begin errors++; $display("FAIL sb_wstrb: got %b exp 1000", mem_wstrb); end
      checks++; if (mem_wdata !== 32'hABAB_ABAB) begin errors++; $display("FAIL sb_wdata: got %h exp abababab", mem_wdata); end
      drive_ack(3, 32'h0, seen);
      checks++; if (seen != 3) begin errors++; $display("FAIL sb_held: got %0d exp 3", seen); end
      checks++; if (done !== 1'b1 || wb_en !== 1'b0 || err !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL sb_done: done=%b wb_en=%b err=%b req=%b exp 1/0/0/0", done, wb_en, err, mem_req); end
      step();
      issue(1'b0, 1'b1, 32'h0000_00A2, 32'h1234_BEEF, LSU_H, 32'h0, 1'b0);
      checks++; if (mem_wstrb !== 4'b1100 || mem_wdata !== 32'hBEEF_BEEF || mem_addr !== 32'h0000_00A0) begin errors++; $display("FAIL sh_lanes: strb=%b wdata=%h addr=%h exp 1100/beefbeef/000000a0", mem_wstrb, mem_wdata, mem_addr); end
      drive_ack(1, 32'h0, seen);
      checks++; if (done !== 1'b1 || wb_en !== 1'b0) begin errors++; $display("FAIL sh_done: done=%b wb_en=%b exp 1/0", done, wb_en); end
      step();
   endtask

   task automatic test_load();
      int seen;
      issue(1'b1, 1'b0, 32'h0000_0102, 32'h0, LSU_B, 32'h0, 1'b1);
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_wstrb !== 4'h0 || mem_addr !== 32'h0000_0100) begin errors++; $display("FAIL lb_bus: req=%b we=%b strb=%b addr=%h exp 1/0/0000/00000100", mem_req, mem_we, mem_wstrb, mem_addr); end
      drive_ack(1, 32'h00F0_0000, seen);
      checks++; if (done !== 1'b1 || wb_data !== 32'hFFFF_FFF0 || wb_en !== 1'b1) begin errors++; $display("FAIL lb_data: done=%b wb_data=%h wb_en=%b exp 1/fffffff0/1", done, wb_data, wb_en); end
      step();
      issue(1'b1, 1'b0, 32'h0000_0102, 32'h0, LSU_BU, 32'h0, 1'b1);
      drive_ack(1, 32'h00F0_0000, seen);
      checks++; if (done !== 1'b1 || wb_data !== 32'h0000_00F0) begin errors++; $display("FAIL lbu_data: done=%b wb_data=%h exp 1/000000f0", done, wb_data); end
      step();
      issue(1'b1, 1'b0, 32'h0000_0202, 32'h0, LSU_H, 32'h0, 1'b1);
      drive_ack(5, 32'h8001_0000, seen);
      checks++; if (seen != 5) begin errors++; $display("FAIL lh_held: got %0d exp 5", seen); end
      checks++; if (done !== 1'b1 || wb_data !== 32'hFFFF_8001 || err !== 1'b0) begin errors++; $display("FAIL lh_data: done=%b wb_data=%h err=%b exp 1/ffff8001/0", done, wb_data, err); end
      step();
      issue(1'b1, 1'b0, 32'h0000_0202, 32'h0, LSU_HU, 32'h0, 1'b1);
      drive_ack(5, 32'h8001_0000, seen);
      checks++; if (done !== 1'b1 || wb_data !== 32'h0000_8001) begin errors++; $display("FAIL lhu_data: done=%b wb_data=%h exp 1/00008001", done, wb_data); end
      step();
   endtask

   task automatic test_errors();
      issue(1'b1, 1'b0, 32'h0000_0101, 32'h0, LSU_W, 32'h0, 1'b1);
      checks++; if (done !== 1'b1 || err !== 1'b1 || wb_en !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL lw_misalign: done=%b err=%b wb_en=%b req=%b exp 1/1/0/0", done, err, wb_en, mem_req); end
      step();
      issue(1'b1, 1'b1, 32'h0000_0100, 32'h0, LSU_W, 32'h0, 1'b1);
      checks++; if (done !== 1'b1 || err !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL rd_wr_both: done=%b err=%b req=%b exp 1/1/0", done, err, mem_req); end
      step();
      issue(1'b1, 1'b0, 32'h0000_0100, 32'h0, 3'b011, 32'h0, 1'b1);
      checks++; if (done !== 1'b1 || err !== 1'b1 || wb_en !== 1'b0) begin errors++; $display("FAIL bad_funct3: done=%b err=%b wb_en=%b exp 1/1/0", done, err, wb_en); end
      step();
   endtask

   task automatic test_timeout();
      int seen;
      seen = 0;
      issue(1'b1, 1'b0, 32'h0000_0300, 32'h0, LSU_W, 32'h0, 1'b1);
      for (int i = 0; i < 20 && done !== 1'b1; i++) begin
         if (mem_req === 1'b1) seen++;
         step();
      end
      checks++; if (done !== 1'b1 || err !== 1'b1 || wb_en !== 1'b0) begin errors++; $display("FAIL timeout_resp: done=%b err=%b wb_en=%b exp 1/1/0", done, err, wb_en); end
      checks++; if (seen != int'(TB_TIMEOUT)) begin errors++; $display("FAIL timeout_held: got %0d exp %0d", seen, TB_TIMEOUT); end
      step();
      mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
      step();
      mem_ack = 1'b0;
      checks++; if (done !== 1'b0 || mem_req !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL late_ack: done=%b req=%b ready=%b exp 0/0/1", done, mem_req, ready); end
   endtask

   task automatic test_back_to_back();
      rd_mem = 1'b0; wr_mem = 1'b0; wr_regfile = 1'b1; result = 32'h0000_00A1;
      req = 1'b1;
      step();
      checks++; if (done !== 1'b1 || wb_data !== 32'h0000_00A1) begin errors++; $display("FAIL b2b_first: done=%b wb_data=%h exp 1/000000a1", done, wb_data); end
      result = 32'h0000_00B2;
      step();
      checks++; if (done !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL b2b_gap: done=%b ready=%b exp 0/1", done, ready); end
      step();
      req = 1'b0;
      checks++; if (done !== 1'b1 || wb_data !== 32'h0000_00B2) begin errors++; $display("FAIL b2b_second: done=%b wb_data=%h exp 1/000000b2", done, wb_data); end
      step();
   endtask

   task automatic test_reset_in_access();
      int seen;
      issue(1'b1, 1'b0, 32'h0000_0400, 32'h0, LSU_W, 32'h0, 1'b1);
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_access_pre: req=%b exp 1", mem_req); end
      #2 reset = 1'b1;
      #1;
      checks++; if (mem_req !== 1'b0 || ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL rst_async: req=%b ready=%b done=%b exp 0/1/0", mem_req, ready, done); end
      #2 reset = 1'b0;
      step();
      checks++; if (done !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL rst_no_done: done=%b ready=%b exp 0/1", done, ready); end
      issue(1'b1, 1'b0, 32'h0000_0404, 32'h0, LSU_W, 32'h0, 1'b1);
      drive_ack(1, 32'hDEAD_BEEF, seen);
      checks++; if (done !== 1'b1 || wb_data !== 32'hDEAD_BEEF || wb_en !== 1'b1) begin errors++; $display("FAIL rst_next_lw: done=%b wb_data=%h wb_en=%b exp 1/deadbeef/1", done, wb_data, wb_en); end
      step();
   endtask

   initial begin
      reset = 1'b1; req = 1'b0; rd_mem = 1'b0; wr_mem = 1'b0; wr_regfile = 1'b0;
      rd_mem_addr = '0; wr_mem_addr = '0; wr_mem_data = '0; funct3 = '0;
      result = '0; mem_ack = 1'b0; mem_rdata = '0;
      test_reset();
      test_nonmem();
      test_store();
      test_load();
      test_errors();
      test_timeout();
      test_back_to_back();
      test_reset_in_access();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
